line_pad_fifo: RTL and testbench

Parametrised row-padding stage between the down sampler and the Gaussian/up-sampler path. Accepts a valid/ready pixel stream, frames each image line of LINE_W pixels with PAD_L leading and PAD_R trailing pad words, and buffers the result in an internal synchronous FIFO. Pad words are either a constant PAD_VALUE or a replica of the line's edge pixel, selected per line. Unlike the fixed single-trailing-pad predecessor, it has left/right padding, edge replication, and true backpressure on FIFO full.

---
 rtl/line_pad_pkg.sv | 17 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/line_pad_fifo.sv | 112 +++++++++++
 tb/tb_line_pad_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/line_pad_pkg.sv
// Shared state encoding and width helpers for the line padding stage.
package line_pad_pkg;

    localparam logic [1:0] S_LEFT   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_RIGHT  = 2'd2;

    // Width of a counter able to reach the largest of the three segment lengths.
    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read port, occupancy level and full/empty flags.
module sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr,
    input  logic [DATA_W-1:0]             din,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             dout,
    output logic                          valid_out,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              do_wr, do_rd;

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign do_wr = wr & ~full;
    assign do_rd = rd_en & ~empty;

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            dout      <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= do_rd;
            if (do_rd) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/line_pad_fifo.sv
// Frames each line with leading/trailing pad words (constant or edge replica) and buffers it.
module line_pad_fifo
    import line_pad_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                LINE_W     = 400,
    parameter int                PAD_L      = 0,
    parameter int                PAD_R      = 1,
    parameter logic [DATA_W-1:0] PAD_VALUE  = {DATA_W{1'b1}},
    parameter int                FIFO_DEPTH = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic                        pad_mode,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           dout,
    output logic                        valid_out,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        line_done
);

    localparam int             CW      = cnt_w(LINE_W, PAD_L, PAD_R);
    localparam logic [1:0]     S_START = (PAD_L > 0) ? S_LEFT : S_ACTIVE;
    localparam logic [CW-1:0]  L_LAST  = CW'(PAD_L > 0 ? PAD_L - 1 : 0);
    localparam logic [CW-1:0]  A_LAST  = CW'(LINE_W - 1);
    localparam logic [CW-1:0]  R_LAST  = CW'(PAD_R > 0 ? PAD_R - 1 : 0);

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic              mode_q, fresh, mode;
    logic [DATA_W-1:0] edge_px, wdata;
    logic              cond, last, wr, line_end, fifo_full;

    // Until the first word of a line is written the mode tracks pad_mode live.
    always_comb begin
        mode  = fresh ? pad_mode : mode_q;
        cond  = 1'b0;
        last  = 1'b0;
        wdata = in_data;
        case (state)
            S_LEFT: begin
                cond  = mode ? in_valid : 1'b1;
                wdata = mode ? in_data : PAD_VALUE;
                last  = (cnt == L_LAST);
            end
            S_ACTIVE: begin
                cond = in_valid;
                last = (cnt == A_LAST);
            end
            S_RIGHT: begin
                cond  = 1'b1;
                wdata = mode ? edge_px : PAD_VALUE;
                last  = (cnt == R_LAST);
            end
            default: ;
        endcase
        wr = cond & ~fifo_full & ~rst;
    end

    assign in_ready  = (state == S_ACTIVE) & ~fifo_full & ~rst;
    assign line_end  = wr & last & ((state == S_RIGHT) | ((state == S_ACTIVE) & (PAD_R == 0)));
    assign line_done = line_end;
    assign full      = fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_START;
            cnt     <= '0;
            mode_q  <= 1'b0;
            fresh   <= 1'b1;
            edge_px <= '0;
        end else begin
            if (fresh) mode_q <= pad_mode;
            if (wr) begin
                fresh <= line_end;
                if (state == S_ACTIVE) edge_px <= in_data;
                if (last) begin
                    cnt <= '0;
                    case (state)
                        S_LEFT:   state <= S_ACTIVE;
                        S_ACTIVE: state <= (PAD_R > 0) ? S_RIGHT : S_START;
                        default:  state <= S_START;
                    endcase
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .din       (wdata),
        .rd_en     (rd_en),
        .dout      (dout),
        .valid_out (valid_out),
        .empty     (empty),
        .full      (fifo_full),
        .level     (level)
    );

endmodule

// File: tb/tb_line_pad_fifo.sv
// Directed bench: a padded-line instance (4+1+2) and a tiny-FIFO backpressure instance.
module tb_line_pad_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: LINE_W=4, PAD_L=1, PAD_R=2, depth 16
    logic       in_valid_a, in_ready_a, pad_mode_a, rd_a, valid_out_a, empty_a, full_a, line_done_a;
    logic [7:0] in_data_a, dout_a;
    logic [4:0] level_a;
    // Instance B: LINE_W=8, no padding, depth 4
    logic       in_valid_b, in_ready_b, pad_mode_b, rd_b, valid_out_b, empty_b, full_b, line_done_b;
    logic [7:0] in_data_b, dout_b;
    logic [2:0] level_b;

    int n_run  = 0;
    int n_fail = 0;

    line_pad_fifo #(.DATA_W(8), .LINE_W(4), .PAD_L(1), .PAD_R(2), .PAD_VALUE(8'hFF), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
        .pad_mode(pad_mode_a), .rd_en(rd_a), .dout(dout_a), .valid_out(valid_out_a),
        .empty(empty_a), .full(full_a), .level(level_a), .line_done(line_done_a));

    line_pad_fifo #(.DATA_W(8), .LINE_W(8), .PAD_L(0), .PAD_R(0), .PAD_VALUE(8'hFF), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .pad_mode(pad_mode_b), .rd_en(rd_b), .dout(dout_b), .valid_out(valid_out_b),
        .empty(empty_b), .full(full_b), .level(level_b), .line_done(line_done_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid_a = 0; in_data_a = 0; rd_a = 0;
        in_valid_b = 0; in_data_b = 0; rd_b = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst = 1'b0;
    endtask

    // Feed 10,11,12,13 into A; stop after stop_pix accepts or one cycle past line_done.
    task automatic line_a(input logic mode, input int stop_pix, input int toggle_after,
                          output int acc10, output int ndone);
        int  idx  = 0;
        bit  done = 0;
        bit  acc;
        acc10 = 0;
        ndone = 0;
        pad_mode_a = mode;
        for (int cyc = 0; cyc < 40 && !done && idx < stop_pix; cyc++) begin
            in_valid_a = (idx < 4);
            in_data_a  = 8'h10 + 8'(idx);
            if (idx >= toggle_after) pad_mode_a = ~mode;
            #1;
            acc = in_valid_a && in_ready_a;
            if (acc && in_data_a == 8'h10) acc10++;
            if (line_done_a) begin ndone++; done = 1; end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid_a = 0;
        if (stop_pix > 4 && !done) chk("line_a timeout", 0, 1);
    endtask

    // Continuous reads from A; exp packs words first-out in the top byte.
    task automatic read_a(input logic [63:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            rd_a = 1;
            @(posedge clk); #1;
            chk($sformatf("A rd%0d vld", i), 32'(valid_out_a), 1);
            chk($sformatf("A rd%0d data", i), 32'(dout_a), 32'(exp[63-8*i -: 8]));
        end
        rd_a = 0;
    endtask

    initial begin
        int a10, nd, idx, got, nld;
        bit acc;
        pad_mode_a = 0; pad_mode_b = 0;

        // Reset state
        do_reset();
        chk("rst in_ready", 32'(in_ready_a), 0);
        chk("rst valid_out", 32'(valid_out_a), 0);
        chk("rst dout", 32'(dout_a), 0);
        chk("rst empty", 32'(empty_a), 1);
        chk("rst full", 32'(full_a), 0);
        chk("rst level", 32'(level_a), 0);
        chk("rst line_done", 32'(line_done_a), 0);

        // Constant padding
        release_reset();
        line_a(0, 99, 99, a10, nd);
        chk("const level", 32'(level_a), 7);
        chk("const line_done", 32'(nd), 1);
        read_a(64'hFF10111213FFFF00, 7);

        // Edge replication; left pad must not consume 10
        do_reset();
        release_reset();
        line_a(1, 99, 99, a10, nd);
        chk("repl level", 32'(level_a), 7);
        chk("repl acc10", 32'(a10), 1);
        chk("repl line_done", 32'(nd), 1);
        repeat (2) @(posedge clk); #1;
        chk("repl level idle", 32'(level_a), 7);
        read_a(64'h1010111213131300, 7);

        // Reset mid-line, then a clean full line
        do_reset();
        release_reset();
        line_a(0, 2, 99, a10, nd);
        chk("mid level pre", 32'(level_a), 3);
        do_reset();
        chk("mid rst empty", 32'(empty_a), 1);
        chk("mid rst level", 32'(level_a), 0);
        release_reset();
        line_a(0, 99, 99, a10, nd);
        chk("mid level", 32'(level_a), 7);
        read_a(64'hFF10111213FFFF00, 7);

        // Mode toggled mid-line: this line stays replicate, next left pad is constant
        do_reset();
        release_reset();
        line_a(1, 99, 2, a10, nd);
        chk("tog line_done", 32'(nd), 1);
        read_a(64'h10101112131313FF, 8);

        // Read on empty, then single write/read on B
        do_reset();
        release_reset();
        rd_b = 1;
        @(posedge clk); #1;
        rd_b = 0;
        chk("B empty rd vld", 32'(valid_out_b), 0);
        chk("B empty rd empty", 32'(empty_b), 1);
        chk("B empty rd dout", 32'(dout_b), 0);
        in_valid_b = 1; in_data_b = 8'h55;
        @(posedge clk); #1;
        in_valid_b = 0;
        chk("B wr level", 32'(level_b), 1);
        rd_b = 1;
        @(posedge clk); #1;
        rd_b = 0;
        chk("B rd vld", 32'(valid_out_b), 1);
        chk("B rd data", 32'(dout_b), 8'h55);
        @(posedge clk); #1;
        chk("B rd vld drop", 32'(valid_out_b), 0);
        chk("B rd dout hold", 32'(dout_b), 8'h55);

        // Backpressure: fill depth-4 FIFO, then drain slowly
        do_reset();
        release_reset();
        idx = 0;
        nld = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_valid_b = 1; in_data_b = 8'h20 + 8'(idx);
            #1;
            acc = in_ready_b;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        #1;
        chk("bp accepts", 32'(idx), 4);
        chk("bp in_ready", 32'(in_ready_b), 0);
        chk("bp full", 32'(full_b), 1);
        chk("bp level", 32'(level_b), 4);
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            in_valid_b = (idx < 8);
            in_data_b  = 8'h20 + 8'(idx);
            rd_b       = (cyc % 3 == 0);
            #1;
            acc = in_valid_b && in_ready_b;
            if (line_done_b) nld++;
            @(posedge clk); #1;
            if (acc) idx++;
            if (valid_out_b) begin
                chk($sformatf("bp out%0d", got), 32'(dout_b), 32'(8'h20 + 8'(got)));
                got++;
            end
        end
        rd_b = 0; in_valid_b = 0;
        chk("bp delivered", 32'(got), 8);
        chk("bp accepted", 32'(idx), 8);
        chk("bp line_done", 32'(nld), 1);
        chk("bp empty", 32'(empty_b), 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
